slv_reset_sequencer: RTL and testbench
======================================

// Module: slv_reset_sequencer
// PURPOSE
//   Consumes the latched reset requests of the write and read guards. On a request it isolates the
//   guarded slave, waits for in-flight responses to go quiet, and holds the slave's reset low for a
//   programmable time. It then waits a recovery interval and pulses reset_clear back to both guards.
//   The block sits between the guards' reset_req outputs and the slave reset / AXI isolation logic.
// PARAMETERS
//   HoldCntWidth   16   width of the reset-hold cycle counter and of rst_hold_cycles_i
//   MaxQuietCycles 256  maximum cycles spent in ISOLATE waiting for a quiet slave (>=1)
//   RecoverCycles  8    cycles between slave-reset release and the reset_clear pulse (>=1)
//   req_t          logic  AXI request type (mst_req_i)
//   rsp_t          logic  AXI response type (slv_rsp_i)
// PORTS
//   clk_i              in   1             clock
//   rst_ni             in   1             synchronous active-low reset
//   wr_reset_req_i     in   1             latched reset request from the write guard
//   rd_reset_req_i     in   1             latched reset request from the read guard
//   mst_req_i          in   req_t         master request; only b_ready/r_ready are sampled
//   slv_rsp_i          in   rsp_t         slave response; only b_valid/r_valid are sampled
//   rst_hold_cycles_i  in   HoldCntWidth  slave reset hold length in cycles; 0 is treated as 1
//   isolate_o          out  1             gate AW/AR/W valids towards the slave while high
//   slv_rst_no         out  1             active-low reset to the guarded slave
//   reset_clear_o      out  1             one-cycle clear pulse to both guards
//   busy_o             out  1             high in every state except IDLE
//   timeout_o          out  1             one-cycle pulse: ISOLATE ended by quiet-timeout, not by quiet
// BEHAVIOUR
//   Reset (rst_ni low at a clock edge):
//     state=IDLE; isolate_o=0, slv_rst_no=1, reset_clear_o=0, busy_o=0, timeout_o=0; all counters 0.
//   req  = wr_reset_req_i | rd_reset_req_i.
//   quiet = !(slv_rsp_i.b_valid & !mst_req_i.b_ready) & !(slv_rsp_i.r_valid & !mst_req_i.r_ready).
//   FSM, all outputs registered:
//     IDLE    : on req, go to ISOLATE next cycle; isolate_o=1 from that cycle.
//     ISOLATE : isolate_o=1; qcnt increments each cycle.
//               On quiet, go to HOLD. Else if qcnt==MaxQuietCycles-1, pulse timeout_o and go to HOLD.
//               Quiet wins when both are true in the same cycle.
//     HOLD    : isolate_o=1, slv_rst_no=0; stays for exactly max(rst_hold_cycles_i,1) cycles.
//               The hold value is captured on ISOLATE->HOLD entry; later changes are ignored.
//     RECOVER : isolate_o=1, slv_rst_no=1; stays RecoverCycles cycles, then goes to CLEAR.
//     CLEAR   : reset_clear_o=1 for exactly one cycle, then go to WAIT.
//     WAIT    : isolate_o=1; go to IDLE on the first cycle req==0 (guards have acknowledged the clear).
//   Latency: req at edge N -> isolate_o high at N+1. With an already-quiet slave and hold=H,
//     slv_rst_no is low from N+2 through N+1+H.
//   The counters are sized to their maxima and never wrap.
//     qcnt: $clog2(MaxQuietCycles+1) bits.
//     Hold counter: HoldCntWidth bits; hold=0 counts as one cycle.
//   Requests arriving while busy_o=1 are absorbed; no second sequence starts.
//     A request still pending in WAIT keeps the FSM in WAIT; it does not retrigger.
//     A guard that re-asserts its request after returning to IDLE starts a new sequence.
//   Simultaneous wr and rd requests are treated as one request.
//   rst_ni low mid-sequence aborts to IDLE at the next edge; slv_rst_no=1 and isolate_o=0 immediately.
// CONFIGURATION
//   SLV_RESET_STATS_EN defined: adds the output port reset_cnt_o [7:0].
//     reset_cnt_o increments on every CLEAR entry, saturates at 255, and is cleared by rst_ni.
//   SLV_RESET_STATS_EN undefined: no reset_cnt_o port and no counter logic; all other behaviour is identical.
// TESTING
//   1. Quiet slave, hold=4, wr_reset_req_i pulsed high at cycle 10
//      -> isolate_o high 11; slv_rst_no low 12..15;
//         reset_clear_o high at 16+RecoverCycles; busy_o low after the req drop.
//   2. b_valid=1, b_ready=0 held forever, MaxQuietCycles=256
//      -> timeout_o pulses once, 256 cycles after ISOLATE entry; HOLD follows.
//   3. Quiet and timeout in the same cycle
//      -> timeout_o stays 0; HOLD is entered.
//   4. rd_reset_req_i rises during HOLD; wr_reset_req_i stays high in WAIT for 5 cycles
//      -> exactly one reset_clear_o pulse; IDLE 1 cycle after the request drops.
//   5. hold=0 -> slv_rst_no low for exactly 1 cycle.
//      Mid-HOLD rst_ni=0 -> next edge slv_rst_no=1, isolate_o=0, busy_o=0.
//   6. With SLV_RESET_STATS_EN: run 257 sequences -> reset_cnt_o=255.
//      Without the macro, the bench compiles without that port.

Source files
------------

// File: rtl/slv_reset_sequencer.sv
// Isolates a guarded slave on a guard reset request, drains responses, pulses its reset, then clears the guards.
// Every output is registered. Optional SLV_RESET_STATS_EN adds a saturating reset_cnt_o sequence counter.
// mst_req_i = {r_ready, b_ready}; slv_rsp_i = {r_valid, b_valid}.
module slv_reset_sequencer #(
    parameter int HoldCntWidth   = 16,
    parameter int MaxQuietCycles = 256,
    parameter int RecoverCycles  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_reset_req_i,
    input  logic                    rd_reset_req_i,
    input  logic [1:0]              mst_req_i,
    input  logic [1:0]              slv_rsp_i,
    input  logic [HoldCntWidth-1:0] rst_hold_cycles_i,
    output logic                    isolate_o,
    output logic                    slv_rst_no,
    output logic                    reset_clear_o,
    output logic                    busy_o,
`ifdef SLV_RESET_STATS_EN
    output logic [7:0]              reset_cnt_o,
`endif
    output logic                    timeout_o
);

    localparam int QW = $clog2(MaxQuietCycles + 1);
    localparam int RW = $clog2(RecoverCycles + 1);
    localparam logic [QW-1:0] QLast = QW'(MaxQuietCycles - 1);
    localparam logic [RW-1:0] RLoad = RW'(RecoverCycles - 1);

    typedef enum logic [2:0] {
        IDLE, ISOLATE, HOLD, RECOVER, CLEAR, WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [QW-1:0]           qcnt_q, qcnt_d;
    logic [HoldCntWidth-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0]           rcnt_q, rcnt_d;
    logic                    isolate_q, isolate_d;
    logic                    slv_rst_n_q, slv_rst_n_d;
    logic                    clear_q, clear_d;
    logic                    busy_q, busy_d;
    logic                    timeout_q, timeout_d;
    logic                    req, quiet;

    assign req   = wr_reset_req_i | rd_reset_req_i;
    assign quiet = !(slv_rsp_i[0] & !mst_req_i[0]) & !(slv_rsp_i[1] & !mst_req_i[1]);

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        hcnt_d    = hcnt_q;
        rcnt_d    = rcnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                qcnt_d = '0;
                if (req) state_d = ISOLATE;
            end
            ISOLATE: begin
                qcnt_d = qcnt_q + QW'(1);
                // Hold length is frozen here; a hold of 0 behaves as 1 cycle.
                hcnt_d = (rst_hold_cycles_i == '0) ? '0 : rst_hold_cycles_i - HoldCntWidth'(1);
                if (quiet) begin
                    state_d = HOLD;
                end else if (qcnt_q == QLast) begin
                    state_d   = HOLD;
                    timeout_d = 1'b1;
                end
            end
            HOLD: begin
                if (hcnt_q == '0) begin
                    state_d = RECOVER;
                    rcnt_d  = RLoad;
                end else begin
                    hcnt_d = hcnt_q - HoldCntWidth'(1);
                end
            end
            RECOVER: begin
                if (rcnt_q == '0) state_d = CLEAR;
                else              rcnt_d  = rcnt_q - RW'(1);
            end
            CLEAR:   state_d = WAIT;
            WAIT:    if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        isolate_d   = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        slv_rst_n_d = (state_d != HOLD);
        clear_d     = (state_d == CLEAR);
    end

`ifdef SLV_RESET_STATS_EN
    logic [7:0] reset_cnt_q, reset_cnt_d;

    always_comb begin
        reset_cnt_d = reset_cnt_q;
        if (state_d == CLEAR && state_q != CLEAR && reset_cnt_q != 8'hff)
            reset_cnt_d = reset_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) reset_cnt_q <= '0;
        else         reset_cnt_q <= reset_cnt_d;
    end

    assign reset_cnt_o = reset_cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            qcnt_q      <= '0;
            hcnt_q      <= '0;
            rcnt_q      <= '0;
            isolate_q   <= 1'b0;
            slv_rst_n_q <= 1'b1;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            hcnt_q      <= hcnt_d;
            rcnt_q      <= rcnt_d;
            isolate_q   <= isolate_d;
            slv_rst_n_q <= slv_rst_n_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign isolate_o     = isolate_q;
    assign slv_rst_no    = slv_rst_n_q;
    assign reset_clear_o = clear_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_slv_reset_sequencer.sv
// Directed bench for slv_reset_sequencer (MaxQuietCycles=256, RecoverCycles=8).
module tb_slv_reset_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wr_reset_req_i, rd_reset_req_i;
    logic [1:0]  mst_req_i, slv_rsp_i;
    logic [15:0] rst_hold_cycles_i;
    logic        isolate_o, slv_rst_no, reset_clear_o, busy_o, timeout_o;
`ifdef SLV_RESET_STATS_EN
    logic [7:0]  reset_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    slv_reset_sequencer #(
        .HoldCntWidth  (16),
        .MaxQuietCycles(256),
        .RecoverCycles (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .wr_reset_req_i   (wr_reset_req_i),
        .rd_reset_req_i   (rd_reset_req_i),
        .mst_req_i        (mst_req_i),
        .slv_rsp_i        (slv_rsp_i),
        .rst_hold_cycles_i(rst_hold_cycles_i),
        .isolate_o        (isolate_o),
        .slv_rst_no       (slv_rst_no),
        .reset_clear_o    (reset_clear_o),
        .busy_o           (busy_o),
`ifdef SLV_RESET_STATS_EN
        .reset_cnt_o      (reset_cnt_o),
`endif
        .timeout_o        (timeout_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; wr_reset_req_i = 1'b0; rd_reset_req_i = 1'b0;
        mst_req_i = 2'b11; slv_rsp_i = 2'b00; rst_hold_cycles_i = 16'd4;
        step(); step();
        total++;
        if ({isolate_o, slv_rst_no, reset_clear_o, busy_o, timeout_o} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_state got=%b want=01000",
                     {isolate_o, slv_rst_no, reset_clear_o, busy_o, timeout_o});
        end
        rst_ni = 1'b1;
        step();
    endtask

    // Quiet slave, hold=4, single-cycle wr pulse; hold changes after capture are ignored.
    task automatic test_basic();
        logic e_iso, e_rst, e_clr;
        wr_reset_req_i = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i == 1) wr_reset_req_i = 1'b0;
            if (i == 2) rst_hold_cycles_i = 16'd9;
            e_iso = (i >= 1 && i <= 15);
            e_rst = !(i >= 2 && i <= 5);
            e_clr = (i == 14);
            total++;
            if ({isolate_o, slv_rst_no, reset_clear_o, busy_o, timeout_o} !== {e_iso, e_rst, e_clr, e_iso, 1'b0}) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%b want=%b", i,
                         {isolate_o, slv_rst_no, reset_clear_o, busy_o, timeout_o},
                         {e_iso, e_rst, e_clr, e_iso, 1'b0});
            end
        end
        rst_hold_cycles_i = 16'd4;
    endtask

    // Stuck b_valid: timeout after 256 ISOLATE cycles. With early_quiet the slave
    // goes quiet exactly in the last ISOLATE cycle, so no timeout must be reported.
    task automatic test_timeout(input logic early_quiet);
        int tcount;
        tcount = 0;
        slv_rsp_i = 2'b01; mst_req_i = 2'b00;
        wr_reset_req_i = 1'b1;
        for (int i = 1; i <= 258; i++) begin
            step();
            if (i == 1) wr_reset_req_i = 1'b0;
            if (i == 256 && early_quiet) slv_rsp_i = 2'b00;
            if (timeout_o) tcount++;
            if (i == 257) begin
                total++;
                if (timeout_o !== !early_quiet || slv_rst_no !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_edge quiet=%0b got to=%b rst_n=%b want to=%b rst_n=0",
                             early_quiet, timeout_o, slv_rst_no, !early_quiet);
                end
            end
            if (i == 256) begin
                total++;
                if (slv_rst_no !== 1'b1 || isolate_o !== 1'b1) begin
                    bad++;
                    $display("FAIL isolate_long got rst_n=%b iso=%b want 1 1", slv_rst_no, isolate_o);
                end
            end
        end
        total++;
        if (tcount != (early_quiet ? 0 : 1)) begin
            bad++;
            $display("FAIL timeout_count quiet=%0b got=%0d want=%0d", early_quiet, tcount, early_quiet ? 0 : 1);
        end
        slv_rsp_i = 2'b00; mst_req_i = 2'b11;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_done busy got=%b want=0", busy_o);
        end
    endtask

    // Requests held through WAIT; rd joins during HOLD. One clear pulse only.
    task automatic test_back_to_back();
        int clears;
        clears = 0;
        rst_hold_cycles_i = 16'd6;
        wr_reset_req_i = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (i == 3) rd_reset_req_i = 1'b1;
            if (i == 21) begin wr_reset_req_i = 1'b0; rd_reset_req_i = 1'b0; end
            if (reset_clear_o) clears++;
            if (i == 16) begin
                total++;
                if (reset_clear_o !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_clear_at16 got=%b want=1", reset_clear_o);
                end
            end
            if (i == 21 || i == 22) begin
                total++;
                if (busy_o !== (i == 21)) begin
                    bad++;
                    $display("FAIL b2b_busy cyc=%0d got=%b want=%b", i, busy_o, i == 21);
                end
            end
        end
        total++;
        if (clears != 1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_single got clears=%0d busy=%b want 1 0", clears, busy_o);
        end
        rst_hold_cycles_i = 16'd4;
    endtask

    // hold=0 gives one reset cycle; then reset asserted mid-HOLD aborts.
    task automatic test_hold_zero_and_abort();
        rst_hold_cycles_i = 16'd0;
        wr_reset_req_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 1) wr_reset_req_i = 1'b0;
            total++;
            if (slv_rst_no !== (i != 2)) begin
                bad++;
                $display("FAIL hold0 cyc=%0d got=%b want=%b", i, slv_rst_no, i != 2);
            end
        end
        for (int i = 0; i < 15; i++) step();
        rst_hold_cycles_i = 16'd10;
        wr_reset_req_i = 1'b1;
        step(); wr_reset_req_i = 1'b0;
        step(); step();
        total++;
        if (slv_rst_no !== 1'b0) begin
            bad++;
            $display("FAIL abort_pre got rst_n=%b want=0", slv_rst_no);
        end
        rst_ni = 1'b0;
        step();
        total++;
        if ({slv_rst_no, isolate_o, busy_o} !== 3'b100) begin
            bad++;
            $display("FAIL abort got=%b want=100", {slv_rst_no, isolate_o, busy_o});
        end
        rst_ni = 1'b1;
        step(); step();
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle busy got=%b want=0", busy_o);
        end
        rst_hold_cycles_i = 16'd4;
    endtask

`ifdef SLV_RESET_STATS_EN
    task automatic test_stats();
        int n;
        rst_ni = 1'b0; step(); rst_ni = 1'b1; step();
        total++;
        if (reset_cnt_o !== 8'd0) begin
            bad++;
            $display("FAIL stats_reset got=%0d want=0", reset_cnt_o);
        end
        rst_hold_cycles_i = 16'd1;
        for (int s = 1; s <= 257; s++) begin
            wr_reset_req_i = 1'b1;
            step();
            wr_reset_req_i = 1'b0;
            n = 0;
            while (busy_o && n < 40) begin step(); n++; end
            if (n >= 40) begin
                total++; bad++;
                $display("FAIL stats_timeout seq=%0d busy=%b", s, busy_o);
            end
            if (s == 1 || s == 255 || s == 257) begin
                total++;
                if (reset_cnt_o !== ((s > 255) ? 8'd255 : 8'(s))) begin
                    bad++;
                    $display("FAIL stats_cnt seq=%0d got=%0d want=%0d", s, reset_cnt_o,
                             (s > 255) ? 255 : s);
                end
            end
        end
        rst_hold_cycles_i = 16'd4;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_hold_zero_and_abort();
`ifdef SLV_RESET_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
